shift_register: RTL and testbench

- Parameterised serial-in, parallel-out shift register with a fixed shift direction and shift step.
- While `load` is high, each rising clock edge moves the register contents by `SHIFT_AMOUNT` positions and fills the vacated bits from the 1-bit serial input `load_vlaue`.
- The full register is always visible on `po`.
- Used as a generic bit-collector or deserialiser in small datapaths.

---
 rtl/shift_register.sv | 82 ++++++++
 tb/tb_shift_register.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/shift_register.sv
// ---------------------------------------------------------------------------
// shift_register
//   Parameterised serial-in / parallel-out shift register. While load is
//   high, every rising clock edge moves the register by SHIFT_AMOUNT bit
//   positions in the fixed SHIFT_DIRECTION. The vacated positions are filled
//   with copies of the serial bit load_vlaue. Bits shifted out are dropped.
//
// Parameters
//   SHIFT_DIRECTION : "LEFT" (toward MSB) or "RIGHT" (toward LSB)
//   SHIFT_AMOUNT    : bit positions moved per enabled edge, 1..WIDTH-1
//   WIDTH           : register width, >= 2
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset, clears the register
//   load       : shift enable
//   load_vlaue : serial input bit
//   po         : parallel register contents (driven straight from the flops)
// ---------------------------------------------------------------------------
module shift_register #(
    parameter string SHIFT_DIRECTION = "LEFT",
    parameter int    SHIFT_AMOUNT    = 1,
    parameter int    WIDTH           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             load_vlaue,
    output logic [WIDTH-1:0] po
);

    logic [WIDTH-1:0]        sr_q;
    logic [WIDTH-1:0]        sr_d;
    logic [WIDTH-1:0]        shifted_s;
    logic [SHIFT_AMOUNT-1:0] fill_s;

    // Parameter legality is enforced at elaboration so a bad configuration
    // never produces silently wrong slicing.
    if (WIDTH < 2) begin : g_bad_width
        $error("shift_register: WIDTH must be at least 2");
    end

    if ((SHIFT_AMOUNT < 1) || (SHIFT_AMOUNT > (WIDTH - 1))) begin : g_bad_amount
        $error("shift_register: SHIFT_AMOUNT must be in 1..WIDTH-1");
    end

    // Every vacated bit takes the same serial value.
    assign fill_s = {SHIFT_AMOUNT{load_vlaue}};

    if (SHIFT_DIRECTION == "LEFT") begin : g_left
        // Top SHIFT_AMOUNT bits fall off the MSB end.
        assign shifted_s = {sr_q[WIDTH-1-SHIFT_AMOUNT:0], fill_s};
    end else if (SHIFT_DIRECTION == "RIGHT") begin : g_right
        // Low SHIFT_AMOUNT bits fall off the LSB end.
        assign shifted_s = {fill_s, sr_q[WIDTH-1:SHIFT_AMOUNT]};
    end else begin : g_bad_dir
        $error("shift_register: SHIFT_DIRECTION must be \"LEFT\" or \"RIGHT\"");
        assign shifted_s = sr_q;
    end

    // Next-state selection: shift when enabled, otherwise hold.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = shifted_s;
        end else begin
            sr_d = sr_q;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= {WIDTH{1'b0}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign po = sr_q;

endmodule

// File: tb/tb_shift_register.sv
// ---------------------------------------------------------------------------
// tb_shift_register
//   Self-checking bench for shift_register. Four instances (LEFT/1, RIGHT/1,
//   LEFT/2, RIGHT/3, all WIDTH=8) share clock, reset and stimulus. Each is
//   compared every cycle to an arithmetic reference model, and the directed
//   scenarios are additionally checked against literal expected values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ns
module tb_shift_register;

    logic       clk;
    logic       rst;
    logic       load;
    logic       load_vlaue;
    logic [7:0] po_l1;
    logic [7:0] po_r1;
    logic [7:0] po_l2;
    logic [7:0] po_r3;

    logic [7:0] m_l1;
    logic [7:0] m_r1;
    logic [7:0] m_l2;
    logic [7:0] m_r3;

    int total;
    int bad;

    shift_register #(.SHIFT_DIRECTION("LEFT"),  .SHIFT_AMOUNT(1), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .load(load), .load_vlaue(load_vlaue), .po(po_l1));
    shift_register #(.SHIFT_DIRECTION("RIGHT"), .SHIFT_AMOUNT(1), .WIDTH(8)) dut_r1 (
        .clk(clk), .rst(rst), .load(load), .load_vlaue(load_vlaue), .po(po_r1));
    shift_register #(.SHIFT_DIRECTION("LEFT"),  .SHIFT_AMOUNT(2), .WIDTH(8)) dut_l2 (
        .clk(clk), .rst(rst), .load(load), .load_vlaue(load_vlaue), .po(po_l2));
    shift_register #(.SHIFT_DIRECTION("RIGHT"), .SHIFT_AMOUNT(3), .WIDTH(8)) dut_r3 (
        .clk(clk), .rst(rst), .load(load), .load_vlaue(load_vlaue), .po(po_r3));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference: multiply/divide by 2^amt, then OR in amt copies of the bit.
    function automatic logic [7:0] nxt(input bit left, input int amt,
                                       input logic [7:0] cur, input logic b);
        int v;
        int fill;
        fill = b ? ((1 << amt) - 1) : 0;
        if (left) v = ((int'(cur) * (1 << amt)) + fill) % 256;
        else      v = (int'(cur) / (1 << amt)) + (fill * (1 << (8 - amt)));
        return 8'(v);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_models(input string tag);
        chk({tag, "_l1"}, po_l1, m_l1);
        chk({tag, "_r1"}, po_r1, m_r1);
        chk({tag, "_l2"}, po_l2, m_l2);
        chk({tag, "_r3"}, po_r3, m_r3);
    endtask

    // One clock: drive on the falling edge, sample 1ns after the rising edge.
    task automatic step(input logic l, input logic d);
        @(negedge clk);
        load       = l;
        load_vlaue = d;
        @(posedge clk);
        if (rst && l) begin
            m_l1 = nxt(1'b1, 1, m_l1, d);
            m_r1 = nxt(1'b0, 1, m_r1, d);
            m_l2 = nxt(1'b1, 2, m_l2, d);
            m_r3 = nxt(1'b0, 3, m_r3, d);
        end
        #1;
        chk_models("model");
    endtask

    // Called just after a rising edge: pulse reset low between edges and
    // confirm the clear happens without any clock edge.
    task automatic pulse_reset();
        #1 rst = 1'b0;
        m_l1 = 8'h00; m_r1 = 8'h00; m_l2 = 8'h00; m_r3 = 8'h00;
        #1;
        chk_models("async_rst");
        #6 rst = 1'b1;
    endtask

    logic [7:0] s2_bits;
    logic [7:0] s2_exp [8];
    logic [7:0] s4_exp [4];
    logic [7:0] s5_exp [3];
    logic [3:0] s4_bits;
    logic [2:0] s5_bits;

    initial begin
        total = 0;
        bad   = 0;
        s2_bits = 8'b0100_1101;   // LSB first: 1,0,1,1,0,0,1,0
        s2_exp  = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
        s4_bits = 4'b1011;        // LSB first: 1,1,0,1
        s4_exp  = '{8'h80, 8'hC0, 8'h60, 8'hB0};
        s5_bits = 3'b101;         // LSB first: 1,0,1
        s5_exp  = '{8'h03, 8'h0C, 8'h33};
        m_l1 = 8'h00; m_r1 = 8'h00; m_l2 = 8'h00; m_r3 = 8'h00;

        // 1. Reset held with load active.
        rst        = 1'b0;
        load       = 1'b1;
        load_vlaue = 1'b1;
        #3;
        chk_models("reset_state");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            chk("rst_hold_po", po_l1, 8'h00);
        end

        // 2. LEFT/1 serial stream.
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, s2_bits[i]);
            chk("left1_stream", po_l1, s2_exp[i]);
        end

        // 3. Hold with load low while data toggles, then one more shift.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'(i % 2));
            chk("hold", po_l1, 8'hB2);
        end
        step(1'b1, 1'b1);
        chk("after_hold", po_l1, 8'h65);

        // Fill with ones, then assert reset asynchronously.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        chk("all_ones", po_l1, 8'hFF);
        pulse_reset();
        chk("async_clear", po_l1, 8'h00);

        // 4. RIGHT/1 serial stream.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, s4_bits[i]);
            chk("right1_stream", po_r1, s4_exp[i]);
        end

        // 5. LEFT/2 stream and RIGHT/3 first bit.
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, s5_bits[i]);
            chk("left2_stream", po_l2, s5_exp[i]);
            if (i == 0) chk("right3_first", po_r3, 8'hE0);
        end

        // 6. Reset mid-stream discards collected bits.
        pulse_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        chk("mid_0f", po_l1, 8'h0F);
        pulse_reset();
        step(1'b1, 1'b1);
        chk("mid_restart", po_l1, 8'h01);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) pulse_reset();
            else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
